// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite slave exposing NUM_REGS 32-bit read/write registers, one transaction in flight.
// Define AXI_LITE_SLAVE_ERR_RESP_EN to answer out-of-range accesses with SLVERR instead of OKAY.
package holy_core_pkg;
  typedef enum logic [1:0] {
    IDLE,
    LITE_RECEIVING_WRITE_DATA,
    LITE_SENDING_WRITE_RES,
    LITE_SENDING_READ_DATA
  } axi_state_slave_t;
endpackage

module axi_lite_reg_slave #(
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic [NUM_REGS*32-1:0]   regs_o
);
  import holy_core_pkg::*;

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_SLAVE_ERR_RESP_EN
  localparam logic [1:0] RESP_OOR = 2'b10;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  axi_state_slave_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] awAddr_q, awAddr_d;
  logic [31:0]           regs_q [NUM_REGS];
  logic [1:0]            bResp_q, bResp_d;
  logic [31:0]           rData_q, rData_d;
  logic [1:0]            rResp_q, rResp_d;
  logic                  wrEn;
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [IDX_W-1:0]      wrIdx;
  logic [IDX_W-1:0]      rdIdx;

  // Power-of-two register count: in range exactly when no word-address bit above the index is set.
  function automatic logic inRange(input logic [ADDR_WIDTH-1:0] a);
    return ~|a[ADDR_WIDTH-1:IDX_W+2];
  endfunction

  assign wrIdx = wrAddr[2 +: IDX_W];
  assign rdIdx = s_axi_araddr[2 +: IDX_W];

  always_comb begin
    state_d       = state_q;
    awAddr_d      = awAddr_q;
    bResp_d       = bResp_q;
    rData_d       = rData_q;
    rResp_d       = rResp_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_rvalid  = 1'b0;
    wrEn          = 1'b0;
    wrAddr        = awAddr_q;
    case (state_q)
      IDLE: begin
        if (s_axi_awvalid) begin
          s_axi_awready = 1'b1;
          awAddr_d      = s_axi_awaddr;
          if (s_axi_wvalid) begin
            s_axi_wready = 1'b1;
            wrEn         = 1'b1;
            wrAddr       = s_axi_awaddr;
            state_d      = LITE_SENDING_WRITE_RES;
          end else begin
            state_d = LITE_RECEIVING_WRITE_DATA;
          end
        end else if (s_axi_arvalid) begin
          s_axi_arready = 1'b1;
          rData_d       = inRange(s_axi_araddr) ? regs_q[rdIdx] : 32'h0;
          rResp_d       = inRange(s_axi_araddr) ? RESP_OKAY : RESP_OOR;
          state_d       = LITE_SENDING_READ_DATA;
        end
      end
      LITE_RECEIVING_WRITE_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          wrEn    = 1'b1;
          state_d = LITE_SENDING_WRITE_RES;
        end
      end
      LITE_SENDING_WRITE_RES: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) state_d = IDLE;
      end
      LITE_SENDING_READ_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (wrEn) bResp_d = inRange(wrAddr) ? RESP_OKAY : RESP_OOR;
    // Ready outputs are combinational, so hold them low while reset is asserted.
    if (!rst_n) begin
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_arready = 1'b0;
      wrEn          = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      awAddr_q <= '0;
      bResp_q  <= 2'b00;
      rData_q  <= 32'h0;
      rResp_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      awAddr_q <= awAddr_d;
      bResp_q  <= bResp_d;
      rData_q  <= rData_d;
      rResp_q  <= rResp_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= 32'h0;
    end else if (wrEn && inRange(wrAddr)) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b]) regs_q[wrIdx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_o[32*k +: 32] = regs_q[k];
  end

  assign s_axi_bresp = bResp_q;
  assign s_axi_rdata = rData_q;
  assign s_axi_rresp = rResp_q;

endmodule

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 Parameter NUM_REGS, default 8, number of 32-bit registers (power of two, 2..256).
REQ-002 Parameter ADDR_WIDTH, default 32, AXI-Lite address width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 s_axi_awaddr  in  ADDR_WIDTH  write address.
REQ-006 s_axi_awvalid / s_axi_awready  in / out  1 / 1  write address handshake.
REQ-007 s_axi_wdata  in  32  write data.
REQ-008 s_axi_wstrb  in  4  byte enables, bit i enables wdata[8i+7:8i].
REQ-009 s_axi_wvalid / s_axi_wready  in / out  1 / 1  write data handshake.
REQ-010 s_axi_bresp  out  2  write response.
REQ-011 s_axi_bvalid / s_axi_bready  out / in  1 / 1  write response handshake.
REQ-012 s_axi_araddr  in  ADDR_WIDTH  read address.
REQ-013 s_axi_arvalid / s_axi_arready  in / out  1 / 1  read address handshake.
REQ-014 s_axi_rdata  out  32  read data.
REQ-015 s_axi_rresp  out  2  read response.
REQ-016 s_axi_rvalid / s_axi_rready  out / in  1 / 1  read data handshake.
REQ-017 regs_o  out  NUM_REGS*32  flat register contents, reg k at [32k+31:32k].

Function
REQ-018 FSM SHALL use holy_core_pkg::axi_state_slave_t: IDLE, LITE_RECEIVING_WRITE_DATA, LITE_SENDING_WRITE_RES, LITE_SENDING_READ_DATA; one transaction in flight.
REQ-019 Decode: index = addr[2 +: log2(NUM_REGS)]; in range iff addr[ADDR_WIDTH-1:2] < NUM_REGS; addr[1:0] ignored.
REQ-020 IDLE, awvalid&wvalid: awready=wready=1 same cycle (combinational); strobed write at that edge; next state LITE_SENDING_WRITE_RES.
REQ-021 IDLE, awvalid&!wvalid: awready=1, awaddr latched; next LITE_RECEIVING_WRITE_DATA. wvalid without awvalid in IDLE: wready=0.
REQ-022 LITE_RECEIVING_WRITE_DATA: awready=0, wready=1; on wvalid write with latched address; next LITE_SENDING_WRITE_RES.
REQ-023 LITE_SENDING_WRITE_RES: bvalid=1, bresp held stable until bready; on bready next IDLE.
REQ-024 IDLE, arvalid&!awvalid: arready=1; rdata/rresp registered at that edge; next LITE_SENDING_READ_DATA. Write wins when awvalid and arvalid coincide.
REQ-025 LITE_SENDING_READ_DATA: rvalid=1, rdata/rresp stable until rready; on rready next IDLE.
REQ-026 Latency: response valid first cycle after final accept; minimum 2 cycles per transaction; no ready asserted outside states above.
REQ-027 Unselected bytes (wstrb bit 0) SHALL keep old value; wstrb=0 is a legal no-op returning OKAY.
REQ-028 regs_o SHALL reflect a write the cycle after the write edge.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, all registers 0, all ready/valid 0, bresp=rresp=2'b00, rdata=0, latched address 0.
REQ-030 Reset mid-transaction SHALL abandon it; no response issued after release.

Configuration
REQ-031 Macro AXI_LITE_SLAVE_ERR_RESP_EN defined: out-of-range write dropped with bresp=2'b10 (SLVERR); out-of-range read returns rdata=0, rresp=2'b10.
REQ-032 Macro undefined: out-of-range write dropped, read rdata=0, both responses 2'b00 (OKAY); handshakes identical.

Verification
REQ-033 AW+W same cycle addr 0x04 data 0xDEADBEEF strb 0xF, bready=1 -> bvalid next cycle, bresp=0, regs_o[63:32]=0xDEADBEEF.
REQ-034 AW addr 0x08, W two cycles later data 0x11223344 strb 0x3 over 0xAAAAAAAA -> reg2=0xAAAA3344, bresp=0.
REQ-035 AR addr 0x04 after REQ-033, rready low 3 cycles -> rvalid held, rdata=0xDEADBEEF stable, completes on rready.
REQ-036 awvalid and arvalid same cycle -> write accepted first, arready=0 until write response taken, read accepted after.
REQ-037 Write/read addr 0x20 (NUM_REGS=8) -> no register changes; resp 2'b10 with macro, 2'b00 without; rdata=0.
REQ-038 rst_n low during LITE_SENDING_READ_DATA -> rvalid=0 immediately, regs_o=0, IDLE after release.
